// File: rtl/gol_gen_sequencer.sv
// One Game-of-Life generation over the row register file: busy for 2N+3 cycles per accepted start.
// start is ignored (not queued) while busy; the display owns the address port only while idle.
module gol_gen_sequencer #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3,
   parameter int WRAP    = 1,
   parameter int GENBITS = 16
) (
   input  logic               ph2,
   input  logic               reset_n,
   input  logic               start,
   input  logic [REGBITS-1:0] disp_ra,
   output logic [WIDTH-1:0]   disp_rd,
   output logic [REGBITS-1:0] ra,
   input  logic [WIDTH-1:0]   rd,
   output logic               regwrite,
   output logic [WIDTH-1:0]   wd,
   output logic               busy,
   output logic               done,
   output logic [GENBITS-1:0] gen_count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LD_PREV = 3'd1;
   localparam logic [2:0] S_LD_CUR  = 3'd2;
   localparam logic [2:0] S_RD_NEXT = 3'd3;
   localparam logic [2:0] S_WR_ROW  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [REGBITS-1:0] LAST_ROW = '1;
   localparam logic [REGBITS-1:0] ONE_ROW  = 1;
   localparam logic [GENBITS-1:0] ONE_GEN  = 1;
   localparam logic               WRAP_EN  = (WRAP != 0);

   logic [2:0]         state_q, state_d;
   logic [REGBITS-1:0] r_q, r_d;
   logic [WIDTH-1:0]   prev_q, prev_d, cur_q, cur_d, next_q, next_d;
   logic [WIDTH-1:0]   row0_q, row0_d;
   logic [GENBITS-1:0] gen_q, gen_d;

   logic [WIDTH+1:0]   pe, ce, ne;
   logic [WIDTH-1:0]   life;
   logic [3:0]         n;

   // Rows padded by one column each side: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
   always_comb begin
      pe   = {WRAP_EN & prev_q[0], prev_q, WRAP_EN & prev_q[WIDTH-1]};
      ce   = {WRAP_EN & cur_q[0],  cur_q,  WRAP_EN & cur_q[WIDTH-1]};
      ne   = {WRAP_EN & next_q[0], next_q, WRAP_EN & next_q[WIDTH-1]};
      n    = '0;
      life = '0;
      for (int c = 0; c < WIDTH; c++) begin
         n = {3'b000, pe[c]} + {3'b000, pe[c+1]} + {3'b000, pe[c+2]}
           + {3'b000, ce[c]}                     + {3'b000, ce[c+2]}
           + {3'b000, ne[c]} + {3'b000, ne[c+1]} + {3'b000, ne[c+2]};
         life[c] = (n == 4'd3) | (ce[c+1] & (n == 4'd2));
      end
   end

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      prev_d   = prev_q;
      cur_d    = cur_q;
      next_d   = next_q;
      row0_d   = row0_q;
      gen_d    = gen_q;
      ra       = disp_ra;
      regwrite = 1'b0;
      wd       = '0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LD_PREV;
         end
         S_LD_PREV: begin
            ra      = LAST_ROW;
            prev_d  = WRAP_EN ? rd : '0;
            state_d = S_LD_CUR;
         end
         S_LD_CUR: begin
            ra      = '0;
            cur_d   = rd;
            row0_d  = rd;
            r_d     = '0;
            state_d = S_RD_NEXT;
         end
         S_RD_NEXT: begin
            ra = r_q + ONE_ROW;
            // Row 0 is already rewritten by the time the last row needs it.
            if (r_q == LAST_ROW) next_d = WRAP_EN ? row0_q : '0;
            else                 next_d = rd;
            state_d = S_WR_ROW;
         end
         S_WR_ROW: begin
            ra       = r_q;
            regwrite = 1'b1;
            wd       = life;
            prev_d   = cur_q;
            cur_d    = next_q;
            if (r_q == LAST_ROW) begin
               state_d = S_DONE;
            end else begin
               r_d     = r_q + ONE_ROW;
               state_d = S_RD_NEXT;
            end
         end
         S_DONE: begin
            gen_d   = gen_q + ONE_GEN;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ph2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         prev_q  <= '0;
         cur_q   <= '0;
         next_q  <= '0;
         row0_q  <= '0;
         gen_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         prev_q  <= prev_d;
         cur_q   <= cur_d;
         next_q  <= next_d;
         row0_q  <= row0_d;
         gen_q   <= gen_d;
      end
   end

   assign disp_rd   = rd;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign gen_count = gen_q;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Directed bench: a toroidal and a dead-edge sequencer, each driving its own row register file.
module tb_gol_gen_sequencer;

   localparam logic [63:0] BLINK_H = 64'h00000000_38000000;
   localparam logic [63:0] BLINK_V = 64'h00000010_10100000;
   localparam logic [63:0] BLOCK   = 64'h00000000_00181800;
   localparam logic [63:0] CORNER  = 64'h01000000_00000101;
   localparam logic [63:0] CORNER1 = 64'h00000000_00000083;
   localparam logic [63:0] EDGE0   = 64'h00000000_000000E0;
   localparam logic [63:0] EDGE1   = 64'h00000000_00004040;

   logic        ph2 = 1'b0;
   logic        reset_n, start, use_dead;
   logic [2:0]  disp_ra;
   logic        start_w, start_d;

   logic [2:0]  ra_w, ra_d;
   logic [7:0]  rd_w, rd_d, wd_w, wd_d, disp_rd_w, disp_rd_d;
   logic        regwrite_w, regwrite_d, busy_w, busy_d, done_w, done_d;
   logic [15:0] gc_w, gc_d;

   logic [7:0]  mem_w [8];
   logic [7:0]  mem_d [8];
   logic        ld_w, ld_d;
   logic [63:0] init_w, init_d;
   logic        c_busy, c_done, c_wr;

   int tests = 0;
   int fails = 0;
   int exp_gc_w = 0;
   int exp_gc_d = 0;

   always #5 ph2 = ~ph2;

   assign start_w = start & ~use_dead;
   assign start_d = start & use_dead;
   assign rd_w    = mem_w[ra_w];
   assign rd_d    = mem_d[ra_d];
   assign c_busy  = use_dead ? busy_d : busy_w;
   assign c_done  = use_dead ? done_d : done_w;
   assign c_wr    = use_dead ? regwrite_d : regwrite_w;

   always @(posedge ph2) begin
      if (ld_w) for (int i = 0; i < 8; i++) mem_w[i] <= init_w[i*8 +: 8];
      else if (regwrite_w) mem_w[ra_w] <= wd_w;
   end

   always @(posedge ph2) begin
      if (ld_d) for (int i = 0; i < 8; i++) mem_d[i] <= init_d[i*8 +: 8];
      else if (regwrite_d) mem_d[ra_d] <= wd_d;
   end

   gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .WRAP(1), .GENBITS(16)) u_wrap (
      .ph2(ph2), .reset_n(reset_n), .start(start_w), .disp_ra(disp_ra), .disp_rd(disp_rd_w),
      .ra(ra_w), .rd(rd_w), .regwrite(regwrite_w), .wd(wd_w), .busy(busy_w), .done(done_w),
      .gen_count(gc_w));

   gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .WRAP(0), .GENBITS(16)) u_dead (
      .ph2(ph2), .reset_n(reset_n), .start(start_d), .disp_ra(disp_ra), .disp_rd(disp_rd_d),
      .ra(ra_d), .rd(rd_d), .regwrite(regwrite_d), .wd(wd_d), .busy(busy_d), .done(done_d),
      .gen_count(gc_d));

   function automatic logic [63:0] board(input logic sel);
      logic [63:0] b;
      for (int i = 0; i < 8; i++) b[i*8 +: 8] = sel ? mem_d[i] : mem_w[i];
      return b;
   endfunction

   task automatic load(input logic sel, input logic [63:0] b);
      @(negedge ph2);
      if (sel) begin init_d = b; ld_d = 1'b1; end
      else     begin init_w = b; ld_w = 1'b1; end
      @(negedge ph2);
      ld_w = 1'b0;
      ld_d = 1'b0;
   endtask

   task automatic run_gen(input logic sel, output int bc, output int dc, output int wc,
                          output logic dlast);
      use_dead = sel;
      bc = 0; dc = 0; wc = 0; dlast = 1'b0;
      start = 1'b1;
      @(negedge ph2);
      start = 1'b0;
      while (c_busy === 1'b1 && bc < 100) begin
         bc++;
         if (c_done === 1'b1) dc++;
         if (c_wr === 1'b1) wc++;
         dlast = c_done;
         @(negedge ph2);
      end
   endtask

   task automatic test_reset();
      #2;
      tests++; if (busy_w !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_w); end
      tests++; if (done_w !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done_w); end
      tests++; if (regwrite_w !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b want 0", regwrite_w); end
      tests++; if (wd_w !== 8'h00) begin fails++; $display("FAIL reset_wd got %h want 00", wd_w); end
      tests++; if (gc_w !== 16'd0) begin fails++; $display("FAIL reset_gen_count got %0d want 0", gc_w); end
      tests++; if (ra_w !== 3'd5) begin fails++; $display("FAIL reset_ra got %0d want 5", ra_w); end
      tests++; if (busy_d !== 1'b0) begin fails++; $display("FAIL reset_busy_dead got %b want 0", busy_d); end
      @(negedge ph2);
      reset_n = 1'b1;
   endtask

   task automatic test_blinker();
      int bc, dc, wc;
      logic dl;
      load(1'b0, BLINK_H);
      run_gen(1'b0, bc, dc, wc, dl);
      exp_gc_w++;
      tests++; if (bc != 19) begin fails++; $display("FAIL blink_busy_cycles got %0d want 19", bc); end
      tests++; if (dc != 1) begin fails++; $display("FAIL blink_done_pulses got %0d want 1", dc); end
      tests++; if (dl !== 1'b1) begin fails++; $display("FAIL blink_done_last got %b want 1", dl); end
      tests++; if (wc != 8) begin fails++; $display("FAIL blink_writes got %0d want 8", wc); end
      tests++; if (board(1'b0) !== BLINK_V) begin fails++; $display("FAIL blink_gen1 got %h want %h", board(1'b0), BLINK_V); end
      tests++; if (gc_w !== 16'(exp_gc_w)) begin fails++; $display("FAIL blink_gen_count1 got %0d want %0d", gc_w, exp_gc_w); end
      tests++; if (wd_w !== 8'h00 || regwrite_w !== 1'b0) begin fails++; $display("FAIL blink_idle_wr got %b/%h want 0/00", regwrite_w, wd_w); end
      run_gen(1'b0, bc, dc, wc, dl);
      exp_gc_w++;
      tests++; if (board(1'b0) !== BLINK_H) begin fails++; $display("FAIL blink_gen2 got %h want %h", board(1'b0), BLINK_H); end
      tests++; if (gc_w !== 16'(exp_gc_w)) begin fails++; $display("FAIL blink_gen_count2 got %0d want %0d", gc_w, exp_gc_w); end
   endtask

   task automatic test_still_block();
      int bc, dc, wc;
      logic dl;
      load(1'b0, BLOCK);
      for (int g = 0; g < 3; g++) begin
         run_gen(1'b0, bc, dc, wc, dl);
         exp_gc_w++;
         tests++; if (wc != 8) begin fails++; $display("FAIL block_writes gen %0d got %0d want 8", g, wc); end
      end
      tests++; if (board(1'b0) !== BLOCK) begin fails++; $display("FAIL block_board got %h want %h", board(1'b0), BLOCK); end
      tests++; if (gc_w !== 16'(exp_gc_w)) begin fails++; $display("FAIL block_gen_count got %0d want %0d", gc_w, exp_gc_w); end
   endtask

   task automatic test_wrap_corner();
      int bc, dc, wc;
      logic dl;
      load(1'b0, CORNER);
      run_gen(1'b0, bc, dc, wc, dl);
      exp_gc_w++;
      tests++; if (board(1'b0) !== CORNER1) begin fails++; $display("FAIL wrap_corner got %h want %h", board(1'b0), CORNER1); end
   endtask

   task automatic test_dead_edge();
      int bc, dc, wc;
      logic dl;
      load(1'b1, EDGE0);
      run_gen(1'b1, bc, dc, wc, dl);
      exp_gc_d++;
      use_dead = 1'b0;
      tests++; if (bc != 19) begin fails++; $display("FAIL dead_busy_cycles got %0d want 19", bc); end
      tests++; if (board(1'b1) !== EDGE1) begin fails++; $display("FAIL dead_edge got %h want %h", board(1'b1), EDGE1); end
      tests++; if (gc_d !== 16'(exp_gc_d)) begin fails++; $display("FAIL dead_gen_count got %0d want %0d", gc_d, exp_gc_d); end
   endtask

   task automatic test_handshake();
      int cyc, idle_bad, t, nd;
      int td [3];
      load(1'b0, BLOCK);
      use_dead = 1'b0;
      start = 1'b1;
      @(negedge ph2);
      start = 1'b0;
      cyc = 0;
      while (busy_w === 1'b1 && cyc < 100) begin
         cyc++;
         start = (cyc == 5);
         @(negedge ph2);
      end
      start = 1'b0;
      exp_gc_w++;
      idle_bad = 0;
      repeat (3) begin
         if (busy_w !== 1'b0) idle_bad++;
         @(negedge ph2);
      end
      tests++; if (cyc != 19) begin fails++; $display("FAIL ignore_busy_cycles got %0d want 19", cyc); end
      tests++; if (idle_bad != 0) begin fails++; $display("FAIL ignore_queued got %0d busy cycles want 0", idle_bad); end

      td = '{0, 0, 0};
      t = 0;
      nd = 0;
      start = 1'b1;
      while (nd < 3 && t < 200) begin
         @(negedge ph2);
         t++;
         if (busy_w === 1'b1 && done_w === 1'b1) begin
            td[nd] = t;
            nd++;
         end
      end
      start = 1'b0;
      exp_gc_w += 3;
      @(negedge ph2);
      tests++; if (busy_w !== 1'b0) begin fails++; $display("FAIL b2b_idle_after got %b want 0", busy_w); end
      @(negedge ph2);
      tests++; if (nd != 3) begin fails++; $display("FAIL b2b_done_count got %0d want 3", nd); end
      tests++; if (td[1] - td[0] != 20) begin fails++; $display("FAIL b2b_spacing1 got %0d want 20", td[1] - td[0]); end
      tests++; if (td[2] - td[1] != 20) begin fails++; $display("FAIL b2b_spacing2 got %0d want 20", td[2] - td[1]); end
      tests++; if (gc_w !== 16'(exp_gc_w)) begin fails++; $display("FAIL b2b_gen_count got %0d want %0d", gc_w, exp_gc_w); end
   endtask

   task automatic test_async_reset();
      int cyc;
      load(1'b0, BLINK_V);
      use_dead = 1'b0;
      disp_ra = 3'd6;
      start = 1'b1;
      @(negedge ph2);
      start = 1'b0;
      cyc = 1;
      while (cyc < 7) begin
         @(negedge ph2);
         cyc++;
      end
      tests++; if (busy_w !== 1'b1) begin fails++; $display("FAIL arst_pre_busy got %b want 1", busy_w); end
      tests++; if (disp_rd_w !== rd_w) begin fails++; $display("FAIL busy_disp_rd got %h want %h", disp_rd_w, rd_w); end
      #1 reset_n = 1'b0;
      #1;
      tests++; if (busy_w !== 1'b0) begin fails++; $display("FAIL arst_busy got %b want 0", busy_w); end
      tests++; if (regwrite_w !== 1'b0) begin fails++; $display("FAIL arst_regwrite got %b want 0", regwrite_w); end
      tests++; if (gc_w !== 16'd0 || gc_d !== 16'd0) begin fails++; $display("FAIL arst_gen_count got %0d/%0d want 0/0", gc_w, gc_d); end
      tests++; if (ra_w !== 3'd6) begin fails++; $display("FAIL arst_ra got %0d want 6", ra_w); end
      exp_gc_w = 0;
      exp_gc_d = 0;
      @(negedge ph2);
      reset_n = 1'b1;
      disp_ra = 3'd3;
      #1;
      tests++; if (ra_w !== 3'd3) begin fails++; $display("FAIL idle_ra got %0d want 3", ra_w); end
      tests++; if (disp_rd_w !== 8'h10) begin fails++; $display("FAIL idle_disp_rd got %h want 10", disp_rd_w); end
      @(negedge ph2);
      tests++; if (busy_w !== 1'b0) begin fails++; $display("FAIL arst_stays_idle got %b want 0", busy_w); end
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      use_dead = 1'b0;
      disp_ra  = 3'd5;
      ld_w     = 1'b0;
      ld_d     = 1'b0;
      init_w   = '0;
      init_d   = '0;
      test_reset();
      test_blinker();
      test_still_block();
      test_wrap_corner();
      test_dead_edge();
      test_handshake();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
